// File: rtl/beep_arbiter.sv
// beep_arbiter
//   Shares one buzzer among NREQ event sources. Requester i plays i+1 beeps
//   at a tone half-period of TONE_HALF*(i+1) cycles. Request edges are latched
//   into pending bits and served one full pattern at a time. The lowest
//   index wins, and a pattern in progress is never preempted.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   req       request lines, rising-edge sensitive
//   beep_pin  buzzer drive, square wave while sounding
//   busy      high whenever the FSM is not IDLE
//   grant     one-hot requester being served, 0 in IDLE
//   done      one-cycle pulse on the last cycle of the post-pattern gap
module beep_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ON_CYC    = 12500000,
  parameter int unsigned OFF_CYC   = 12500000,
  parameter int unsigned GAP_CYC   = 25000000,
  parameter int unsigned TONE_HALF = 40000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic            beep_pin,
  output logic            busy,
  output logic [NREQ-1:0] grant,
  output logic            done
);

  localparam int unsigned MAX_OG = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned MAX_D  = (MAX_OG > GAP_CYC) ? MAX_OG : GAP_CYC;
  localparam int unsigned DUR_W  = $clog2(MAX_D + 1);
  localparam int unsigned TONE_W = $clog2(TONE_HALF * NREQ + 1);
  localparam int unsigned BEEP_W = $clog2(NREQ + 1);

  localparam logic [DUR_W-1:0] ON_LAST  = DUR_W'(ON_CYC - 1);
  localparam logic [DUR_W-1:0] OFF_LAST = DUR_W'(OFF_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_CYC - 1);
  // done is registered, so it is raised one cycle ahead of the last GAP cycle.
  localparam logic [DUR_W-1:0] GAP_PRE  = DUR_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
  localparam logic             GAP_ONE  = (GAP_CYC == 1);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t            state;
  logic [NREQ-1:0]   req_d;
  logic [NREQ-1:0]   pending;
  logic [DUR_W-1:0]  dur_cnt;
  logic [TONE_W-1:0] tone_cnt;
  logic [TONE_W-1:0] half;
  logic [BEEP_W-1:0] beeps_left;

  logic [NREQ-1:0]   req_edge;
  logic [NREQ-1:0]   sel_onehot;
  logic [NREQ-1:0]   clr_mask;
  logic [TONE_W-1:0] sel_half;
  logic [BEEP_W-1:0] sel_beeps;
  logic              sel_valid;

  assign req_edge = req & ~req_d;
  assign busy     = (state != IDLE);

  // Lowest set pending index wins.
  always_comb begin
    sel_onehot = '0;
    sel_half   = '0;
    sel_beeps  = '0;
    sel_valid  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pending[i] && !sel_valid) begin
        sel_valid     = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_half      = TONE_W'(TONE_HALF * (i + 1));
        sel_beeps     = BEEP_W'(i + 1);
      end
    end
  end

  assign clr_mask = (state == IDLE) ? sel_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_d      <= '0;
      pending    <= '0;
      dur_cnt    <= '0;
      tone_cnt   <= '0;
      half       <= '0;
      beeps_left <= '0;
      beep_pin   <= 1'b0;
      grant      <= '0;
      done       <= 1'b0;
    end else begin
      req_d <= req;
      // Clear the granted bit before merging new edges, so an edge on the
      // index granted this very cycle is kept for a replay.
      pending <= (pending & ~clr_mask) | req_edge;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state      <= ON;
            grant      <= sel_onehot;
            beeps_left <= sel_beeps;
            half       <= sel_half;
            dur_cnt    <= '0;
            tone_cnt   <= '0;
            beep_pin   <= 1'b0;
          end
        end
        ON: begin
          if (dur_cnt == ON_LAST) begin
            dur_cnt    <= '0;
            tone_cnt   <= '0;
            beep_pin   <= 1'b0;
            beeps_left <= beeps_left - 1'b1;
            if (beeps_left > BEEP_W'(1)) begin
              state <= OFF;
            end else begin
              state <= GAP;
              done  <= GAP_ONE;
            end
          end else begin
            dur_cnt <= dur_cnt + 1'b1;
            if (tone_cnt == half - 1'b1) begin
              beep_pin <= ~beep_pin;
              tone_cnt <= '0;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end
        OFF: begin
          if (dur_cnt == OFF_LAST) begin
            state    <= ON;
            dur_cnt  <= '0;
            tone_cnt <= '0;
          end else begin
            dur_cnt <= dur_cnt + 1'b1;
          end
        end
        GAP: begin
          if (dur_cnt == GAP_LAST) begin
            state   <= IDLE;
            grant   <= '0;
            dur_cnt <= '0;
          end else begin
            dur_cnt <= dur_cnt + 1'b1;
            done    <= !GAP_ONE && (dur_cnt == GAP_PRE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beep_arbiter.sv
// tb_beep_arbiter
//   Directed bench for beep_arbiter with ON=10, OFF=6, GAP=4, TONE_HALF=2,
//   NREQ=4. Outputs are sampled 1 time unit after each rising clock edge as
//   the tuple {beep_pin, busy, grant[3:0], done}.
module tb_beep_arbiter;

  localparam int unsigned NONE = 32'hFFFF_FFF0;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       beep_pin;
  logic       busy;
  logic [3:0] grant;
  logic       done;

  int unsigned vectors;
  int unsigned miscompares;

  beep_arbiter #(
    .NREQ(4),
    .ON_CYC(10),
    .OFF_CYC(6),
    .GAP_CYC(4),
    .TONE_HALF(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .beep_pin(beep_pin),
    .busy(busy),
    .grant(grant),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {beep_pin, busy, grant, done};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Walks one full pattern for requester k, starting at its first ON cycle,
  // and ends on the IDLE cycle after done. Optionally pulses req for one
  // cycle at pattern-relative cycle poke_at.
  task automatic serve(input int unsigned k, input int unsigned poke_at,
                       input logic [3:0] poke_v);
    int unsigned h;
    int unsigned n;
    logic [3:0]  g;
    logic        bv;
    h = 2 * (k + 1);
    n = 0;
    g = 4'b0001 << k;
    for (int unsigned b = 0; b <= k; b++) begin
      for (int unsigned c = 0; c < 10; c++) begin
        bv = ((c / h) % 2) != 0;
        chk("on", {bv, 1'b1, g, 1'b0});
        if (n == poke_at) req = poke_v;
        else if (n == poke_at + 1) req = '0;
        tick(); n++;
      end
      if (b < k) begin
        for (int unsigned c = 0; c < 6; c++) begin
          chk("off", {1'b0, 1'b1, g, 1'b0});
          if (n == poke_at) req = poke_v;
          else if (n == poke_at + 1) req = '0;
          tick(); n++;
        end
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      chk("gap", {1'b0, 1'b1, g, (c == 3)});
      if (n == poke_at) req = poke_v;
      else if (n == poke_at + 1) req = '0;
      tick(); n++;
    end
    chk("idle_after", 7'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req         = '0;
    tick(); tick();
    chk("reset", 7'b0);
    rst_n = 1'b1;
    tick();
    chk("post_reset", 7'b0);

    // single pulse on req[0]
    req = 4'b0001; tick();
    chk("t1_pend", 7'b0);
    req = '0; tick();
    serve(0, NONE, '0);

    // req[1]: two beeps
    tick();
    req = 4'b0010; tick();
    req = '0; tick();
    serve(1, NONE, '0);

    // simultaneous req[0] and req[2]
    tick();
    req = 4'b0101; tick();
    req = '0; tick();
    serve(0, NONE, '0);
    tick();
    serve(2, NONE, '0);
    tick();
    chk("t3_quiet", 7'b0);

    // req[3] held high: one pattern only
    req = 4'b1000; tick(); tick();
    serve(3, NONE, '0);
    for (int unsigned i = 0; i < 135; i++) begin
      tick();
      chk("t4_held_idle", 7'b0);
    end
    req = '0; tick();
    chk("t4_release", 7'b0);

    // req[3] re-requested during ON replays after done
    req = 4'b1000; tick();
    req = '0; tick();
    serve(3, 3, 4'b1000);
    tick();
    serve(3, NONE, '0);
    tick();
    chk("t4_no_third", 7'b0);

    // req[0] arriving while req[2] is in OFF waits its turn
    req = 4'b0100; tick();
    req = '0; tick();
    serve(2, 12, 4'b0001);
    tick();
    serve(0, NONE, '0);
    tick();
    chk("t6_quiet", 7'b0);

    // reset mid-ON with req[1] pending
    req = 4'b0011; tick();
    req = '0; tick();
    chk("t5_on0", 7'b0100010);
    tick(); tick(); tick();
    chk("t5_on3", 7'b1100010);
    #2 rst_n = 1'b0;
    #1 chk("t5_async", 7'b0);
    tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 30; i++) begin
      tick();
      chk("t5_silent", 7'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
